control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Moore FSM sequencing the 32-bit bus datapath: fetch, decode, execute.
//  Drives all bus *out/*in strobes, ALU operation, IncPC and memory Read/Write.
//  Per cycle: at most one bus driver, so the datapath encoder never sees two.
//  Memory accesses stall on mem_ready; an optional watchdog escalates to fault.
// PARAMETERS
//  OPC_W        5   opcode width, IR[31:27]
//  ALU_OP_W     4   width of operation bus into alu
//  MEM_TIMEOUT  0   max stall cycles per access; 0 = watchdog disabled
// PORTS
//  Clock        in   1   rising-edge clock
//  clear        in   1   synchronous, active-high reset
//  IR           in   32  instruction register contents
//  mem_ready    in   1   memory completed current Read/Write this cycle
//  PCout,Zlowout,Zhighout,HIout,LOout,MDRout,Cout  out 1 each  bus drivers
//  MARin,PCin,MDRin,IRin,Yin,Zin_low,Zin_high,HIin,LOin  out 1 each  loads
//  IncPC,Read,Write  out 1 each  PC-increment mode, memory read/write
//  operation    out  4   ALU opcode (cpu_pkg encoding)
//  R_out        out  16  one-hot GP register bus driver (R0out..R15out)
//  R_in         out  16  one-hot GP register load (R0in..R15in)
//  run          out  1   high except in HALT and FAULT
//  fault        out  1   watchdog expired; sticky until clear
// BEHAVIOUR
//  All outputs decoded from state reg + IR (no output regs, zero latency).
//  clear=1 at edge -> state RESET; all outputs 0 incl run, fault. Mid-instr clear aborts, no partial write-back.
//  RESET -> T0 next cycle unconditionally.
//  Fetch:
//   T0: PCout, MARin, IncPC, Zin_low.
//   T1: Read, MDRin; hold T1 while mem_ready=0; PCin+Zlowout only on exit cycle.
//   T2: MDRout, IRin. Next: T3, or T0 if opcode undefined/NOP.
//  Fields: Ra=IR[26:23] Rb=IR[22:19] Rc=IR[18:15]; C=IR[18:0] via Cout.
//  ALU reg (ADD SUB AND OR SHL SHR ROL ROR): T3 Rout(Rb),Yin; T4 Rout(Rc),
//   operation,Zin_low; T5 Zlowout,Rin(Ra) -> T0.
//  ALU imm (ADDI ANDI ORI): as above, T4 uses Cout instead of Rout(Rc).
//  Unary (NEG NOT): T3 Rout(Rb),operation,Zin_low; T4 Zlowout,Rin(Ra) -> T0.
//  MUL/DIV: T3 Rout(Ra),Yin; T4 Rout(Rb),operation,Zin_low,Zin_high;
//   T5 Zlowout,LOin; T6 Zhighout,HIin -> T0.
//  LD: T3 Rout(Rb),Yin; T4 Cout,op=ADD,Zin_low; T5 Zlowout,MARin;
//   T6 Read,MDRin, hold while !mem_ready; T7 MDRout,Rin(Ra) -> T0.
//  ST: T3-T5 as LD; T6 Rout(Ra),MDRin (Read=0); T7 Write, hold while !mem_ready -> T0.
//  HALT: T3 -> HALT; remain until clear; run=0, all strobes 0.
//  Watchdog: stall counter clears on entering T1/T6(LD)/T7(ST); when
//   MEM_TIMEOUT>0 and count reaches MEM_TIMEOUT without mem_ready -> FAULT (sticky).
//  mem_ready outside a wait state is ignored. R0 is an ordinary register.
//  operation = 0 (cpu_pkg ALU_NOP) whenever no Zin_* asserted, except T0 (IncPC path).
// STRUCTURE
//  cpu_pkg: opcode localparams (OPC_ADD..OPC_HALT), ALU op codes, state
//   encoding, IR field bit positions. Shared with alu and testbench.
//  Sub-module reg_select_decode: IR + {selA,selB,selC,rin,rout} -> one-hot
//   R_in/R_out; guarantees one-hot or zero.
//  Top: state reg, next-state logic, output decode, watchdog counter.
// TESTING
//  Reset: clear 3 cycles mid-T4 -> all outputs 0 next edge; T0 two edges after release.
//  ADD R1,R2,R3 (IR=0x18918000 per cpu_pkg), mem_ready=1 -> T0..T5 in 6 cycles;
//   T5 R_in=16'h0002, Zlowout=1; T4 operation=ALU_ADD, R_out=16'h0008.
//  LD R4,0x10(R5), mem_ready low 3 cycles in T6 -> Read/MDRin held 4 cycles,
//   T7 R_in=16'h0010; total 11 cycles.
//  MUL R6,R7 -> T5 LOin=1, T6 HIin=1, Zhighout=1; R_in=0 throughout.
//  MEM_TIMEOUT=4, mem_ready stuck 0 in T1 -> fault=1, run=0 after 4 stall cycles; stays until clear.
//  Every cycle, all sequences: popcount(all *out + R_out) <= 1 assertion never fires.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// Shared encodings for the bus-datapath sequencer: opcodes, ALU operations,
// FSM states, IR field positions and the opcode classification helpers.
package control_sequencer_pkg;

    localparam int OPC_W    = 5;
    localparam int ALU_OP_W = 4;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

    typedef logic [OPC_W-1:0] opcode_t;

    localparam opcode_t OPC_LD   = 5'd0;
    localparam opcode_t OPC_ST   = 5'd2;
    localparam opcode_t OPC_ADD  = 5'd3;
    localparam opcode_t OPC_SUB  = 5'd4;
    localparam opcode_t OPC_AND  = 5'd5;
    localparam opcode_t OPC_OR   = 5'd6;
    localparam opcode_t OPC_ROR  = 5'd7;
    localparam opcode_t OPC_ROL  = 5'd8;
    localparam opcode_t OPC_SHR  = 5'd9;
    localparam opcode_t OPC_SHL  = 5'd11;
    localparam opcode_t OPC_ADDI = 5'd12;
    localparam opcode_t OPC_ANDI = 5'd13;
    localparam opcode_t OPC_ORI  = 5'd14;
    localparam opcode_t OPC_MUL  = 5'd15;
    localparam opcode_t OPC_DIV  = 5'd16;
    localparam opcode_t OPC_NEG  = 5'd17;
    localparam opcode_t OPC_NOT  = 5'd18;
    localparam opcode_t OPC_NOP  = 5'd26;
    localparam opcode_t OPC_HALT = 5'd27;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_NOP = 4'd0,
        ALU_ADD = 4'd1,
        ALU_SUB = 4'd2,
        ALU_AND = 4'd3,
        ALU_OR  = 4'd4,
        ALU_SHL = 4'd5,
        ALU_SHR = 4'd6,
        ALU_ROL = 4'd7,
        ALU_ROR = 4'd8,
        ALU_MUL = 4'd9,
        ALU_DIV = 4'd10,
        ALU_NEG = 4'd11,
        ALU_NOT = 4'd12
    } alu_op_t;

    typedef enum logic [3:0] {
        ST_RESET, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4,
        ST_T5, ST_T6, ST_T7, ST_HALT, ST_FAULT
    } state_t;

    // Instruction classes share one micro-sequence each; NONE covers NOP and undefined.
    typedef enum logic [2:0] {
        CLS_NONE, CLS_ALU_REG, CLS_ALU_IMM, CLS_UNARY,
        CLS_MULDIV, CLS_LOAD, CLS_STORE, CLS_HALT
    } opc_class_t;

    function automatic opc_class_t classify(input opcode_t opc);
        case (opc)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR,
            OPC_SHL, OPC_SHR, OPC_ROL, OPC_ROR: return CLS_ALU_REG;
            OPC_ADDI, OPC_ANDI, OPC_ORI:        return CLS_ALU_IMM;
            OPC_NEG, OPC_NOT:                   return CLS_UNARY;
            OPC_MUL, OPC_DIV:                   return CLS_MULDIV;
            OPC_LD:                             return CLS_LOAD;
            OPC_ST:                             return CLS_STORE;
            OPC_HALT:                           return CLS_HALT;
            default:                            return CLS_NONE;
        endcase
    endfunction

    function automatic alu_op_t alu_op_of(input opcode_t opc);
        case (opc)
            OPC_ADD, OPC_ADDI, OPC_LD, OPC_ST: return ALU_ADD;
            OPC_SUB:                           return ALU_SUB;
            OPC_AND, OPC_ANDI:                 return ALU_AND;
            OPC_OR, OPC_ORI:                   return ALU_OR;
            OPC_SHL:                           return ALU_SHL;
            OPC_SHR:                           return ALU_SHR;
            OPC_ROL:                           return ALU_ROL;
            OPC_ROR:                           return ALU_ROR;
            OPC_MUL:                           return ALU_MUL;
            OPC_DIV:                           return ALU_DIV;
            OPC_NEG:                           return ALU_NEG;
            OPC_NOT:                           return ALU_NOT;
            default:                           return ALU_NOP;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer (master) and the 32-bit bus datapath (slave).
interface control_sequencer_if;
    import control_sequencer_pkg::*;

    logic [31:0]         IR;
    logic                mem_ready;
    logic                PCout, Zlowout, Zhighout, HIout, LOout, MDRout, Cout;
    logic                MARin, PCin, MDRin, IRin, Yin, Zin_low, Zin_high, HIin, LOin;
    logic                IncPC, Read, Write;
    logic [ALU_OP_W-1:0] operation;
    logic [15:0]         R_out;
    logic [15:0]         R_in;
    logic                run;
    logic                fault;

    modport master (
        input  IR, mem_ready,
        output PCout, Zlowout, Zhighout, HIout, LOout, MDRout, Cout,
        output MARin, PCin, MDRin, IRin, Yin, Zin_low, Zin_high, HIin, LOin,
        output IncPC, Read, Write, operation, R_out, R_in, run, fault
    );

    modport slave (
        output IR, mem_ready,
        input  PCout, Zlowout, Zhighout, HIout, LOout, MDRout, Cout,
        input  MARin, PCin, MDRin, IRin, Yin, Zin_low, Zin_high, HIin, LOin,
        input  IncPC, Read, Write, operation, R_out, R_in, run, fault
    );

endinterface

// File: rtl/control_sequencer_reg_select_decode.sv
// Picks one IR register field and expands it to one-hot R_in / R_out strobes.
module control_sequencer_reg_select_decode (
    input  logic [3:0]  ra,
    input  logic [3:0]  rb,
    input  logic [3:0]  rc,
    input  logic        sel_a,
    input  logic        sel_b,
    input  logic        sel_c,
    input  logic        rin,
    input  logic        rout,
    output logic [15:0] r_in,
    output logic [15:0] r_out
);

    logic [3:0]  field;
    logic        any_sel;
    logic [15:0] onehot;

    // Priority selection keeps the result one-hot even if several selects are raised.
    always_comb begin
        field = 4'd0;
        if (sel_a) begin
            field = ra;
        end else if (sel_b) begin
            field = rb;
        end else if (sel_c) begin
            field = rc;
        end
    end

    assign any_sel = sel_a | sel_b | sel_c;

    for (genvar gi = 0; gi < 16; gi++) begin : g_onehot
        assign onehot[gi] = any_sel && (field == 4'(gi));
    end

    assign r_in  = rin ? onehot : 16'h0000;
    assign r_out = (rout && !rin) ? onehot : 16'h0000;

endmodule

// File: rtl/control_sequencer.sv
// Moore sequencer for the fetch/decode/execute micro-steps of the bus datapath,
// with memory stall handling and an optional stall watchdog.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 0
) (
    input logic               Clock,
    input logic               clear,
    control_sequencer_if.master bus
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST_STALL = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;

    state_t           state_reg;
    logic [CNT_W-1:0] stall_cnt_reg;
    opc_class_t       cls;
    alu_op_t          exec_op;
    alu_op_t          op;
    logic             in_wait;
    logic             wd_expire;
    logic             sel_a, sel_b, sel_c, rin, rout;
    logic             unused_c_field;

    // The immediate field is routed to the datapath directly, not through here.
    assign unused_c_field = ^bus.IR[14:0];

    assign cls     = classify(bus.IR[OPC_MSB:OPC_LSB]);
    assign exec_op = alu_op_of(bus.IR[OPC_MSB:OPC_LSB]);

    assign in_wait = (state_reg == ST_T1)
                  || (state_reg == ST_T6 && cls == CLS_LOAD)
                  || (state_reg == ST_T7 && cls == CLS_STORE);

    assign wd_expire = (MEM_TIMEOUT > 0) && in_wait && !bus.mem_ready
                    && (stall_cnt_reg == LAST_STALL);

    always_ff @(posedge Clock) begin
        if (clear) begin
            state_reg     <= ST_RESET;
            stall_cnt_reg <= '0;
        end else begin
            stall_cnt_reg <= (in_wait && !bus.mem_ready) ? stall_cnt_reg + CNT_W'(1) : '0;
            if (wd_expire) begin
                state_reg <= ST_FAULT;
            end else begin
                case (state_reg)
                    ST_RESET: state_reg <= ST_T0;
                    ST_T0:    state_reg <= ST_T1;
                    ST_T1:    if (bus.mem_ready) state_reg <= ST_T2;
                    ST_T2:    state_reg <= (cls == CLS_NONE) ? ST_T0 : ST_T3;
                    ST_T3:    state_reg <= (cls == CLS_HALT) ? ST_HALT : ST_T4;
                    ST_T4:    state_reg <= (cls == CLS_UNARY) ? ST_T0 : ST_T5;
                    ST_T5:    state_reg <= (cls == CLS_ALU_REG || cls == CLS_ALU_IMM) ? ST_T0 : ST_T6;
                    ST_T6: begin
                        if (cls == CLS_LOAD) begin
                            if (bus.mem_ready) state_reg <= ST_T7;
                        end else if (cls == CLS_STORE) begin
                            state_reg <= ST_T7;
                        end else begin
                            state_reg <= ST_T0;
                        end
                    end
                    ST_T7: begin
                        if (cls != CLS_STORE || bus.mem_ready) state_reg <= ST_T0;
                    end
                    ST_HALT:  state_reg <= ST_HALT;
                    ST_FAULT: state_reg <= ST_FAULT;
                    default:  state_reg <= ST_RESET;
                endcase
            end
        end
    end

    always_comb begin
        bus.PCout = 1'b0; bus.Zlowout = 1'b0; bus.Zhighout = 1'b0; bus.HIout = 1'b0;
        bus.LOout = 1'b0; bus.MDRout = 1'b0; bus.Cout = 1'b0;
        bus.MARin = 1'b0; bus.PCin = 1'b0; bus.MDRin = 1'b0; bus.IRin = 1'b0; bus.Yin = 1'b0;
        bus.Zin_low = 1'b0; bus.Zin_high = 1'b0; bus.HIin = 1'b0; bus.LOin = 1'b0;
        bus.IncPC = 1'b0; bus.Read = 1'b0; bus.Write = 1'b0;
        sel_a = 1'b0; sel_b = 1'b0; sel_c = 1'b0; rin = 1'b0; rout = 1'b0;
        op = ALU_NOP;
        case (state_reg)
            ST_T0: begin
                bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin_low = 1'b1;
            end
            ST_T1: begin
                bus.Read = 1'b1; bus.MDRin = 1'b1;
                // The incremented PC is only committed on the cycle the fetch completes.
                if (bus.mem_ready) begin
                    bus.PCin = 1'b1; bus.Zlowout = 1'b1;
                end
            end
            ST_T2: begin
                bus.MDRout = 1'b1; bus.IRin = 1'b1;
            end
            ST_T3: begin
                case (cls)
                    CLS_ALU_REG, CLS_ALU_IMM, CLS_LOAD, CLS_STORE: begin
                        rout = 1'b1; sel_b = 1'b1; bus.Yin = 1'b1;
                    end
                    CLS_UNARY: begin
                        rout = 1'b1; sel_b = 1'b1; op = exec_op; bus.Zin_low = 1'b1;
                    end
                    CLS_MULDIV: begin
                        rout = 1'b1; sel_a = 1'b1; bus.Yin = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T4: begin
                case (cls)
                    CLS_ALU_REG: begin
                        rout = 1'b1; sel_c = 1'b1; op = exec_op; bus.Zin_low = 1'b1;
                    end
                    CLS_ALU_IMM: begin
                        bus.Cout = 1'b1; op = exec_op; bus.Zin_low = 1'b1;
                    end
                    CLS_UNARY: begin
                        bus.Zlowout = 1'b1; rin = 1'b1; sel_a = 1'b1;
                    end
                    CLS_MULDIV: begin
                        rout = 1'b1; sel_b = 1'b1; op = exec_op;
                        bus.Zin_low = 1'b1; bus.Zin_high = 1'b1;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        bus.Cout = 1'b1; op = ALU_ADD; bus.Zin_low = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (cls)
                    CLS_ALU_REG, CLS_ALU_IMM: begin
                        bus.Zlowout = 1'b1; rin = 1'b1; sel_a = 1'b1;
                    end
                    CLS_MULDIV:          begin bus.Zlowout = 1'b1; bus.LOin = 1'b1; end
                    CLS_LOAD, CLS_STORE: begin bus.Zlowout = 1'b1; bus.MARin = 1'b1; end
                    default: ;
                endcase
            end
            ST_T6: begin
                case (cls)
                    CLS_MULDIV: begin bus.Zhighout = 1'b1; bus.HIin = 1'b1; end
                    CLS_LOAD:   begin bus.Read = 1'b1; bus.MDRin = 1'b1; end
                    CLS_STORE:  begin rout = 1'b1; sel_a = 1'b1; bus.MDRin = 1'b1; end
                    default: ;
                endcase
            end
            ST_T7: begin
                case (cls)
                    CLS_LOAD:  begin bus.MDRout = 1'b1; rin = 1'b1; sel_a = 1'b1; end
                    CLS_STORE: bus.Write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
        bus.operation = op;
        bus.run   = !(state_reg == ST_RESET || state_reg == ST_HALT || state_reg == ST_FAULT);
        bus.fault = (state_reg == ST_FAULT);
    end

    control_sequencer_reg_select_decode u_reg_select (
        .ra    (bus.IR[RA_MSB:RA_LSB]),
        .rb    (bus.IR[RB_MSB:RB_LSB]),
        .rc    (bus.IR[RC_MSB:RC_LSB]),
        .sel_a (sel_a),
        .sel_b (sel_b),
        .sel_c (sel_c),
        .rin   (rin),
        .rout  (rout),
        .r_in  (bus.R_in),
        .r_out (bus.R_out)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// Directed, table-driven bench for control_sequencer with hand-computed expectations.
module tb_control_sequencer;
    import control_sequencer_pkg::*;

    logic Clock = 1'b0;
    logic clear;

    control_sequencer_if bus ();

    control_sequencer #(.MEM_TIMEOUT(4)) dut (
        .Clock (Clock),
        .clear (clear),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    localparam logic [20:0] S_PCOUT = 21'h000001;
    localparam logic [20:0] S_ZLO   = 21'h000002;
    localparam logic [20:0] S_ZHI   = 21'h000004;
    localparam logic [20:0] S_MDRO  = 21'h000020;
    localparam logic [20:0] S_COUT  = 21'h000040;
    localparam logic [20:0] S_MARIN = 21'h000080;
    localparam logic [20:0] S_PCIN  = 21'h000100;
    localparam logic [20:0] S_MDRIN = 21'h000200;
    localparam logic [20:0] S_IRIN  = 21'h000400;
    localparam logic [20:0] S_YIN   = 21'h000800;
    localparam logic [20:0] S_ZINL  = 21'h001000;
    localparam logic [20:0] S_ZINH  = 21'h002000;
    localparam logic [20:0] S_HIIN  = 21'h004000;
    localparam logic [20:0] S_LOIN  = 21'h008000;
    localparam logic [20:0] S_INCPC = 21'h010000;
    localparam logic [20:0] S_READ  = 21'h020000;
    localparam logic [20:0] S_WRITE = 21'h040000;
    localparam logic [20:0] S_RUN   = 21'h080000;
    localparam logic [20:0] S_FAULT = 21'h100000;

    localparam logic [20:0] F_T0  = S_PCOUT | S_MARIN | S_INCPC | S_ZINL | S_RUN;
    localparam logic [20:0] F_T1S = S_READ | S_MDRIN | S_RUN;
    localparam logic [20:0] F_T1  = S_READ | S_MDRIN | S_PCIN | S_ZLO | S_RUN;
    localparam logic [20:0] F_T2  = S_MDRO | S_IRIN | S_RUN;

    localparam logic [31:0] IR_ADD  = 32'h18918000;  // ADD  R1,R2,R3
    localparam logic [31:0] IR_LD   = 32'h02280010;  // LD   R4,0x10(R5)
    localparam logic [31:0] IR_MUL  = 32'h7B380000;  // MUL  R6,R7
    localparam logic [31:0] IR_ST   = 32'h14480004;  // ST   R8,0x4(R9)
    localparam logic [31:0] IR_NEG  = 32'h8D580000;  // NEG  R10,R11
    localparam logic [31:0] IR_ADDI = 32'h60780123;  // ADDI R0,R15,0x123
    localparam logic [31:0] IR_NOP  = 32'hD0000000;
    localparam logic [31:0] IR_UND  = 32'hF8000000;
    localparam logic [31:0] IR_HALT = 32'hD8000000;

    typedef struct packed {
        logic [31:0] ir;
        logic        mr;
        logic [20:0] st;
        logic [3:0]  op;
        logic [15:0] ro;
        logic [15:0] ri;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [20:0] actual_strobes();
        return {bus.fault, bus.run, bus.Write, bus.Read, bus.IncPC, bus.LOin, bus.HIin,
                bus.Zin_high, bus.Zin_low, bus.Yin, bus.IRin, bus.MDRin, bus.PCin, bus.MARin,
                bus.Cout, bus.MDRout, bus.LOout, bus.HIout, bus.Zhighout, bus.Zlowout, bus.PCout};
    endfunction

    task automatic add(input logic [31:0] ir, input logic mr, input logic [20:0] st,
                       input logic [3:0] op, input logic [15:0] ro, input logic [15:0] ri);
        vec_t v;
        v.ir = ir; v.mr = mr; v.st = st; v.op = op; v.ro = ro; v.ri = ri;
        vecs.push_back(v);
    endtask

    task automatic add_fetch(input logic [31:0] ir);
        add(ir, 1'b1, F_T0, ALU_NOP, 16'h0, 16'h0);
        add(ir, 1'b1, F_T1, ALU_NOP, 16'h0, 16'h0);
        add(ir, 1'b1, F_T2, ALU_NOP, 16'h0, 16'h0);
    endtask

    // Sets inputs mid-cycle; outputs are sampled 1 time unit later, well clear of posedge.
    task automatic step(input logic [31:0] ir, input logic mr, input logic clr);
        @(negedge Clock);
        bus.IR = ir; bus.mem_ready = mr; clear = clr;
        #1;
    endtask

    task automatic check(input string tag, input logic [20:0] st, input logic [3:0] op,
                         input logic [15:0] ro, input logic [15:0] ri);
        n_cmp++;
        if ({actual_strobes(), bus.operation, bus.R_out, bus.R_in} !== {st, op, ro, ri}) begin
            n_bad++;
            $display("FAIL %s: got strobes=%h op=%0d R_out=%h R_in=%h, want strobes=%h op=%0d R_out=%h R_in=%h",
                     tag, actual_strobes(), bus.operation, bus.R_out, bus.R_in, st, op, ro, ri);
        end else begin
            $display("ok   %s: strobes=%h op=%0d R_out=%h R_in=%h", tag, st, op, ro, ri);
        end
    endtask

    // At most one bus driver in any cycle.
    always @(negedge Clock) begin
        #2;
        n_cmp++;
        if ($countones({bus.PCout, bus.Zlowout, bus.Zhighout, bus.HIout, bus.LOout,
                        bus.MDRout, bus.Cout, bus.R_out}) > 1) begin
            n_bad++;
            $display("FAIL bus_drivers at %0t: got R_out=%h strobes=%h, want at most one driver",
                     $time, bus.R_out, actual_strobes());
        end
    end

    initial begin
        // ADD R1,R2,R3
        add_fetch(IR_ADD);
        add(IR_ADD, 1'b1, S_YIN | S_RUN,  ALU_NOP, 16'h0004, 16'h0000);
        add(IR_ADD, 1'b1, S_ZINL | S_RUN, ALU_ADD, 16'h0008, 16'h0000);
        add(IR_ADD, 1'b1, S_ZLO | S_RUN,  ALU_NOP, 16'h0000, 16'h0002);
        // LD R4,0x10(R5) with three stall cycles in T6
        add_fetch(IR_LD);
        add(IR_LD, 1'b1, S_YIN | S_RUN,           ALU_NOP, 16'h0020, 16'h0000);
        add(IR_LD, 1'b1, S_COUT | S_ZINL | S_RUN, ALU_ADD, 16'h0000, 16'h0000);
        add(IR_LD, 1'b1, S_ZLO | S_MARIN | S_RUN, ALU_NOP, 16'h0000, 16'h0000);
        for (int k = 0; k < 3; k++) add(IR_LD, 1'b0, S_READ | S_MDRIN | S_RUN, ALU_NOP, 16'h0, 16'h0);
        add(IR_LD, 1'b1, S_READ | S_MDRIN | S_RUN, ALU_NOP, 16'h0000, 16'h0000);
        add(IR_LD, 1'b1, S_MDRO | S_RUN,           ALU_NOP, 16'h0000, 16'h0010);
        // MUL R6,R7
        add_fetch(IR_MUL);
        add(IR_MUL, 1'b1, S_YIN | S_RUN,            ALU_NOP, 16'h0040, 16'h0000);
        add(IR_MUL, 1'b1, S_ZINL | S_ZINH | S_RUN,  ALU_MUL, 16'h0080, 16'h0000);
        add(IR_MUL, 1'b1, S_ZLO | S_LOIN | S_RUN,   ALU_NOP, 16'h0000, 16'h0000);
        add(IR_MUL, 1'b1, S_ZHI | S_HIIN | S_RUN,   ALU_NOP, 16'h0000, 16'h0000);
        // ST R8,0x4(R9): fetch stall, mem_ready ignored in T6, write stall in T7
        add(IR_ST, 1'b1, F_T0,  ALU_NOP, 16'h0, 16'h0);
        add(IR_ST, 1'b0, F_T1S, ALU_NOP, 16'h0, 16'h0);
        add(IR_ST, 1'b1, F_T1,  ALU_NOP, 16'h0, 16'h0);
        add(IR_ST, 1'b1, F_T2,  ALU_NOP, 16'h0, 16'h0);
        add(IR_ST, 1'b1, S_YIN | S_RUN,           ALU_NOP, 16'h0200, 16'h0000);
        add(IR_ST, 1'b1, S_COUT | S_ZINL | S_RUN, ALU_ADD, 16'h0000, 16'h0000);
        add(IR_ST, 1'b1, S_ZLO | S_MARIN | S_RUN, ALU_NOP, 16'h0000, 16'h0000);
        add(IR_ST, 1'b1, S_MDRIN | S_RUN,         ALU_NOP, 16'h0100, 16'h0000);
        add(IR_ST, 1'b0, S_WRITE | S_RUN,         ALU_NOP, 16'h0000, 16'h0000);
        add(IR_ST, 1'b1, S_WRITE | S_RUN,         ALU_NOP, 16'h0000, 16'h0000);
        // NEG R10,R11
        add_fetch(IR_NEG);
        add(IR_NEG, 1'b1, S_ZINL | S_RUN, ALU_NEG, 16'h0800, 16'h0000);
        add(IR_NEG, 1'b1, S_ZLO | S_RUN,  ALU_NOP, 16'h0000, 16'h0400);
        // ADDI R0,R15,0x123
        add_fetch(IR_ADDI);
        add(IR_ADDI, 1'b1, S_YIN | S_RUN,           ALU_NOP, 16'h8000, 16'h0000);
        add(IR_ADDI, 1'b1, S_COUT | S_ZINL | S_RUN, ALU_ADD, 16'h0000, 16'h0000);
        add(IR_ADDI, 1'b1, S_ZLO | S_RUN,           ALU_NOP, 16'h0000, 16'h0001);
        // NOP and undefined opcode return to T0 after T2
        add_fetch(IR_NOP);
        add_fetch(IR_UND);
        // HALT
        add_fetch(IR_HALT);
        add(IR_HALT, 1'b1, S_RUN, ALU_NOP, 16'h0, 16'h0);
        add(IR_HALT, 1'b1, 21'h0, ALU_NOP, 16'h0, 16'h0);
        add(IR_HALT, 1'b1, 21'h0, ALU_NOP, 16'h0, 16'h0);

        bus.IR = 32'h0; bus.mem_ready = 1'b0; clear = 1'b1;
        step(32'h0, 1'b0, 1'b1);
        check("reset_a", 21'h0, ALU_NOP, 16'h0, 16'h0);
        step(32'h0, 1'b0, 1'b0);
        check("reset_release", 21'h0, ALU_NOP, 16'h0, 16'h0);

        foreach (vecs[i]) begin
            step(vecs[i].ir, vecs[i].mr, 1'b0);
            check($sformatf("vec%0d", i), vecs[i].st, vecs[i].op, vecs[i].ro, vecs[i].ri);
        end

        // Clear from HALT, then abort an ADD in T4 with a 3-cycle clear
        step(IR_ADD, 1'b1, 1'b1);
        check("halt_clear", 21'h0, ALU_NOP, 16'h0, 16'h0);
        step(IR_ADD, 1'b1, 1'b0);
        check("halt_to_reset", 21'h0, ALU_NOP, 16'h0, 16'h0);
        step(IR_ADD, 1'b1, 1'b0);
        check("abort_t0", F_T0, ALU_NOP, 16'h0, 16'h0);
        for (int k = 0; k < 3; k++) step(IR_ADD, 1'b1, 1'b0);
        step(IR_ADD, 1'b1, 1'b1);
        check("abort_mid_t4", S_ZINL | S_RUN, ALU_ADD, 16'h0008, 16'h0000);
        step(IR_ADD, 1'b1, 1'b1);
        check("abort_clear_1", 21'h0, ALU_NOP, 16'h0, 16'h0);
        step(IR_ADD, 1'b1, 1'b1);
        check("abort_clear_2", 21'h0, ALU_NOP, 16'h0, 16'h0);
        step(IR_ADD, 1'b1, 1'b0);
        check("abort_release", 21'h0, ALU_NOP, 16'h0, 16'h0);
        step(IR_ADD, 1'b1, 1'b0);
        check("abort_t0_again", F_T0, ALU_NOP, 16'h0, 16'h0);

        // Watchdog: four stall cycles in T1 escalate to a sticky fault
        for (int k = 0; k < 4; k++) begin
            step(IR_ADD, 1'b0, 1'b0);
            check($sformatf("wd_stall%0d", k), F_T1S, ALU_NOP, 16'h0, 16'h0);
        end
        step(IR_ADD, 1'b0, 1'b0);
        check("wd_fault", S_FAULT, ALU_NOP, 16'h0, 16'h0);
        step(IR_ADD, 1'b1, 1'b0);
        check("wd_sticky", S_FAULT, ALU_NOP, 16'h0, 16'h0);
        step(IR_ADD, 1'b1, 1'b1);
        check("wd_sticky_2", S_FAULT, ALU_NOP, 16'h0, 16'h0);
        step(IR_ADD, 1'b1, 1'b0);
        check("wd_cleared", 21'h0, ALU_NOP, 16'h0, 16'h0);
        step(IR_ADD, 1'b1, 1'b0);
        check("wd_restart_t0", F_T0, ALU_NOP, 16'h0, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
